tlk2711_link_ctrl: RTL and testbench



---
 rtl/tlk2711_link_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tlk2711_link_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_link_ctrl.sv
// Bring-up and run sequencer for one TLK2711 lane and its 16-bit datapath (clk_80 domain).
// Optional PRBS loopback self-test after power-up: define TLK2711_PRBS_SELFTEST_EN.
//  state | meaning
//  OFF   | PHY powered down, waiting for i_link_en
//  PWRUP | ENABLE high, LCKREFN held low while REFCLK locks
//  PRBS  | internal-loopback PRBS self-test (optional build only)
//  TRAIN | transmit commas, wait for SYNC_CNT consecutive rx commas
//  READY | aligned and idle, comma watchdog running
//  RUN   | datapath running, rx errors counted
//  STOP  | stop requested, waiting for datapath acknowledge
//  FAULT | PHY disabled until i_clear
module tlk2711_link_ctrl #(
  parameter int LOCK_CYCLES   = 80000,
  parameter int SYNC_CNT      = 16,
  parameter int COMMA_TIMEOUT = 4096,
  parameter int STOP_TIMEOUT  = 1024,
  parameter int ERR_MAX       = 8,
  parameter int PRBS_CYCLES   = 65536
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        i_link_en,
  input  logic        i_start,
  input  logic [2:0]  i_mode,
  input  logic        i_stop,
  input  logic        i_clear,
  input  logic        i_rx_valid,
  input  logic [15:0] i_rxd,
  input  logic        i_rklsb,
  input  logic        i_rx_err,
  input  logic        i_dp_stop_ack,
  output logic        o_enable,
  output logic        o_lckrefn,
  output logic        o_loopen,
  output logic        o_prbsen,
  output logic        o_testen,
  output logic        o_tx_comma,
  output logic        o_dp_start,
  output logic [2:0]  o_dp_mode,
  output logic        o_dp_stop,
  output logic        o_link_up,
  output logic [2:0]  o_state,
  output logic [15:0] o_err_cnt
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_PRBS  = 3'd2,
    S_TRAIN = 3'd3,
    S_READY = 3'd4,
    S_RUN   = 3'd5,
    S_STOP  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [15:0] err_cnt;
  logic [2:0]  dp_mode;
  logic        dp_start;
  logic        comma;
  logic        start_go;
  logic        unused_rxd_hi;

  assign comma         = i_rx_valid & i_rklsb & (i_rxd[7:0] == 8'hBC);
  assign unused_rxd_hi = ^i_rxd[15:8];

  // cnt is a down-timer in timed states and an up-counter in TRAIN (commas) and RUN (error run)
  function automatic logic [31:0] entry_load(input state_t s);
    case (s)
      S_PWRUP: return 32'(LOCK_CYCLES - 1);
      S_PRBS:  return 32'(PRBS_CYCLES - 1);
      S_READY: return 32'(COMMA_TIMEOUT - 1);
      S_STOP:  return 32'(STOP_TIMEOUT - 1);
      default: return '0;
    endcase
  endfunction

`ifdef TLK2711_PRBS_SELFTEST_EN
  logic prbs_bad;
  logic prbs_miss;
  // first 256 cycles of the window are settle time and are not checked
  assign prbs_miss = (state == S_PRBS) && (cnt <= 32'(PRBS_CYCLES - 257)) && !i_rklsb;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_OFF: if (i_link_en) state_nxt = S_PWRUP;
      S_PWRUP: begin
        if (cnt == '0) begin
`ifdef TLK2711_PRBS_SELFTEST_EN
          state_nxt = S_PRBS;
`else
          state_nxt = S_TRAIN;
`endif
        end else cnt_nxt = cnt - 32'd1;
      end
      S_PRBS: begin
`ifdef TLK2711_PRBS_SELFTEST_EN
        if (cnt == '0) state_nxt = (prbs_bad || prbs_miss) ? S_FAULT : S_TRAIN;
        else cnt_nxt = cnt - 32'd1;
`else
        state_nxt = S_TRAIN;
`endif
      end
      S_TRAIN: begin
        if (comma) begin
          if (cnt == 32'(SYNC_CNT - 1)) state_nxt = S_READY;
          else cnt_nxt = cnt + 32'd1;
        end else if (i_rx_valid) cnt_nxt = '0;
      end
      S_READY: begin
        if (i_start && !i_stop) state_nxt = S_RUN;
        else if (comma) cnt_nxt = entry_load(S_READY);
        else if (cnt == '0) state_nxt = S_TRAIN;
        else cnt_nxt = cnt - 32'd1;
      end
      S_RUN: begin
        if (i_stop) state_nxt = S_STOP;
        else if (i_rx_err) begin
          if (cnt == 32'(ERR_MAX - 1)) state_nxt = S_TRAIN;
          else cnt_nxt = cnt + 32'd1;
        end else cnt_nxt = '0;
      end
      S_STOP: begin
        if (i_dp_stop_ack) state_nxt = S_READY;
        else if (cnt == '0) state_nxt = S_FAULT;
        else cnt_nxt = cnt - 32'd1;
      end
      S_FAULT: if (i_clear) state_nxt = S_OFF;
      default: state_nxt = S_OFF;
    endcase
    // FAULT deliberately ignores i_link_en so a fault stays visible until cleared
    if (!i_link_en && state != S_FAULT) state_nxt = S_OFF;
    if (state_nxt != state) cnt_nxt = entry_load(state_nxt);
  end

  assign start_go = (state == S_READY) && (state_nxt == S_RUN);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= S_OFF;
      cnt      <= '0;
      dp_start <= 1'b0;
      dp_mode  <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dp_start <= start_go;
      if (state_nxt == S_FAULT) dp_mode <= '0;
      else if (start_go) dp_mode <= i_mode;
      if (i_clear) err_cnt <= '0;
      else if (state == S_RUN && i_rx_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

`ifdef TLK2711_PRBS_SELFTEST_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) prbs_bad <= 1'b0;
    else if (state_nxt != state) prbs_bad <= 1'b0;
    else if (prbs_miss) prbs_bad <= 1'b1;
  end

  assign o_loopen = (state == S_PRBS);
  assign o_prbsen = (state == S_PRBS);
`else
  assign o_loopen = 1'b0;
  assign o_prbsen = 1'b0;
`endif

  assign o_enable   = (state != S_OFF) && (state != S_FAULT);
  assign o_lckrefn  = (state == S_PRBS) || (state == S_TRAIN) || (state == S_READY) ||
                      (state == S_RUN) || (state == S_STOP);
  assign o_testen   = 1'b0;
  assign o_tx_comma = (state == S_TRAIN) || (state == S_READY);
  assign o_dp_start = dp_start;
  assign o_dp_mode  = dp_mode;
  assign o_dp_stop  = (state == S_STOP);
  assign o_link_up  = (state == S_READY) || (state == S_RUN) || (state == S_STOP);
  assign o_state    = state;
  assign o_err_cnt  = err_cnt;

endmodule

// File: tb/tb_tlk2711_link_ctrl.sv
// Bench for tlk2711_link_ctrl: cycle model of the link rules plus directed bring-up/run/fault vectors.
// Honours TLK2711_PRBS_SELFTEST_EN in the same way as the design.
module tb_tlk2711_link_ctrl;

  localparam int LOCK = 100, SYNC = 4, CTO = 50, STO = 20, EMAX = 3, PRBSC = 400;
  localparam int ST_OFF = 0, ST_PWRUP = 1, ST_PRBS = 2, ST_TRAIN = 3,
                 ST_READY = 4, ST_RUN = 5, ST_STOP = 6, ST_FAULT = 7;
`ifdef TLK2711_PRBS_SELFTEST_EN
  localparam bit PRBS_ON = 1'b1;
`else
  localparam bit PRBS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        i_link_en = 0, i_start = 0, i_stop = 0, i_clear = 0;
  logic [2:0]  i_mode = 0;
  logic        i_rx_valid = 0, i_rklsb = 1, i_rx_err = 0, i_dp_stop_ack = 0;
  logic [15:0] i_rxd = 0;
  logic        o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen, o_tx_comma;
  logic        o_dp_start, o_dp_stop, o_link_up;
  logic [2:0]  o_dp_mode, o_state;
  logic [15:0] o_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tlk2711_link_ctrl #(
    .LOCK_CYCLES(LOCK), .SYNC_CNT(SYNC), .COMMA_TIMEOUT(CTO),
    .STOP_TIMEOUT(STO), .ERR_MAX(EMAX), .PRBS_CYCLES(PRBSC)
  ) dut (
    .clk(clk), .arst_n(arst_n), .i_link_en(i_link_en), .i_start(i_start),
    .i_mode(i_mode), .i_stop(i_stop), .i_clear(i_clear), .i_rx_valid(i_rx_valid),
    .i_rxd(i_rxd), .i_rklsb(i_rklsb), .i_rx_err(i_rx_err), .i_dp_stop_ack(i_dp_stop_ack),
    .o_enable(o_enable), .o_lckrefn(o_lckrefn), .o_loopen(o_loopen), .o_prbsen(o_prbsen),
    .o_testen(o_testen), .o_tx_comma(o_tx_comma), .o_dp_start(o_dp_start),
    .o_dp_mode(o_dp_mode), .o_dp_stop(o_dp_stop), .o_link_up(o_link_up),
    .o_state(o_state), .o_err_cnt(o_err_cnt)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: time-in-state, run-length counters and a state number per the link rules
  int m_state, m_age, m_commas, m_quiet, m_run, m_mode, m_errs, m_nxt;
  bit m_pulse, m_bad, m_comma;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_state = ST_OFF; m_age = 0; m_commas = 0; m_quiet = 0; m_run = 0;
      m_mode = 0; m_errs = 0; m_pulse = 0; m_bad = 0;
    end else begin
      m_comma = i_rx_valid && i_rklsb && (i_rxd[7:0] == 8'hBC);
      m_nxt = m_state;
      if (i_clear) m_errs = 0;
      else if (m_state == ST_RUN && i_rx_err && m_errs < 65535) m_errs++;
      case (m_state)
        ST_OFF:   if (i_link_en) m_nxt = ST_PWRUP;
        ST_PWRUP: if (m_age + 1 == LOCK) m_nxt = PRBS_ON ? ST_PRBS : ST_TRAIN;
        ST_PRBS: begin
          if (m_age >= 256 && !i_rklsb) m_bad = 1;
          if (m_age + 1 == PRBSC) m_nxt = m_bad ? ST_FAULT : ST_TRAIN;
        end
        ST_TRAIN: begin
          if (m_comma) m_commas++;
          else if (i_rx_valid) m_commas = 0;
          if (m_commas == SYNC) m_nxt = ST_READY;
        end
        ST_READY: begin
          if (m_comma) m_quiet = 0; else m_quiet++;
          if (i_start && !i_stop) m_nxt = ST_RUN;
          else if (m_quiet == CTO) m_nxt = ST_TRAIN;
        end
        ST_RUN: begin
          if (i_rx_err) m_run++; else m_run = 0;
          if (i_stop) m_nxt = ST_STOP;
          else if (m_run == EMAX) m_nxt = ST_TRAIN;
        end
        ST_STOP: begin
          if (i_dp_stop_ack) m_nxt = ST_READY;
          else if (m_age + 1 == STO) m_nxt = ST_FAULT;
        end
        default: if (i_clear) m_nxt = ST_OFF;
      endcase
      if (!i_link_en && m_state != ST_FAULT) m_nxt = ST_OFF;
      m_pulse = (m_state == ST_READY && m_nxt == ST_RUN);
      if (m_pulse) m_mode = int'(i_mode);
      if (m_nxt == ST_FAULT) m_mode = 0;
      if (m_nxt != m_state) begin
        m_age = 0; m_commas = 0; m_quiet = 0; m_run = 0; m_bad = 0;
      end else m_age++;
      m_state = m_nxt;
    end
  end

  always @(negedge clk) begin
    chk("state",    o_state,    m_state);
    chk("enable",   o_enable,   int'(m_state != ST_OFF && m_state != ST_FAULT));
    chk("lckrefn",  o_lckrefn,  int'(m_state inside {ST_PRBS, ST_TRAIN, ST_READY, ST_RUN, ST_STOP}));
    chk("loopen",   o_loopen,   int'(m_state == ST_PRBS));
    chk("prbsen",   o_prbsen,   int'(m_state == ST_PRBS));
    chk("testen",   o_testen,   0);
    chk("tx_comma", o_tx_comma, int'(m_state == ST_TRAIN || m_state == ST_READY));
    chk("dp_start", o_dp_start, int'(m_pulse));
    chk("dp_mode",  o_dp_mode,  m_mode);
    chk("dp_stop",  o_dp_stop,  int'(m_state == ST_STOP));
    chk("link_up",  o_link_up,  int'(m_state inside {ST_READY, ST_RUN, ST_STOP}));
    chk("err_cnt",  o_err_cnt,  m_errs);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit v, input logic [15:0] d, input bit k, input int n);
    i_rx_valid = v; i_rxd = d; i_rklsb = k;
    repeat (n) step();
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int n = 0;
    while (int'(o_state) != s && n < budget) begin
      step();
      n++;
    end
    chk(nm, o_state, s);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at t=%0t, expected to finish", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int hi;
    #1 arst_n = 1'b0;
    #7;
    chk("rst_state", o_state, 0);
    chk("rst_enable", o_enable, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    chk("rst_link_up", o_link_up, 0);
    #15 arst_n = 1'b1;
    step();
    chk("off_idle", o_state, ST_OFF);

    // bring-up
    i_link_en = 1; step();
    chk("pwrup_state", o_state, ST_PWRUP);
    chk("pwrup_enable", o_enable, 1);
    repeat (LOCK - 1) step();
    chk("lckrefn_held", o_lckrefn, 0);
    step();
    chk("lckrefn_release", o_lckrefn, 1);
    wait_state(ST_TRAIN, 1000, "train_reached");
    send(1, 16'h00BC, 1, SYNC - 1);
    chk("train_3_commas", o_state, ST_TRAIN);
    send(1, 16'h00BC, 1, 1);
    chk("ready_state", o_state, ST_READY);
    chk("ready_link_up", o_link_up, 1);

    // start / stop with ack after 7 cycles
    i_mode = 3'd5; i_start = 1; step(); i_start = 0; i_mode = 3'd2;
    chk("run_state", o_state, ST_RUN);
    chk("dp_start_pulse", o_dp_start, 1);
    chk("dp_mode_latched", o_dp_mode, 5);
    step();
    chk("dp_start_single", o_dp_start, 0);
    chk("dp_mode_held", o_dp_mode, 5);
    i_stop = 1; step(); i_stop = 0;
    hi = int'(o_dp_stop);
    repeat (6) begin step(); hi += int'(o_dp_stop); end
    i_dp_stop_ack = 1; step(); i_dp_stop_ack = 0;
    chk("dp_stop_width", hi, 7);
    chk("stop_to_ready", o_state, ST_READY);
    chk("dp_stop_low", o_dp_stop, 0);

    // stop timeout -> FAULT -> clear -> OFF -> PWRUP
    i_mode = 3'd3; i_start = 1; step(); i_start = 0;
    i_stop = 1; step(); i_stop = 0;
    repeat (STO - 1) step();
    chk("stop_waiting", o_state, ST_STOP);
    step();
    chk("stop_timeout_fault", o_state, ST_FAULT);
    chk("fault_enable", o_enable, 0);
    chk("fault_dp_mode", o_dp_mode, 0);
    i_rx_valid = 0; i_rklsb = 1;
    i_clear = 1; step(); i_clear = 0;
    chk("clear_to_off", o_state, ST_OFF);
    step();
    chk("off_to_pwrup", o_state, ST_PWRUP);
    wait_state(ST_TRAIN, 1000, "retrain_after_fault");
    send(1, 16'h00BC, 1, SYNC);
    chk("ready_again", o_state, ST_READY);

    // rx error run in RUN: 2 errors, 1 clean, 3 errors
    i_mode = 3'd1; i_start = 1; step(); i_start = 0;
    i_rx_valid = 0;
    i_rx_err = 1; step(); step();
    i_rx_err = 0; step();
    i_rx_err = 1; step(); step();
    chk("err_run_survives", o_state, ST_RUN);
    chk("err_cnt_4", o_err_cnt, 4);
    step(); i_rx_err = 0;
    chk("err_retrain", o_state, ST_TRAIN);
    chk("err_cnt_5", o_err_cnt, 5);

    // broken alignment
    send(1, 16'h00BC, 1, 3);
    send(1, 16'h1234, 0, 1);
    send(1, 16'h00BC, 1, 3);
    chk("broken_still_train", o_state, ST_TRAIN);
    send(1, 16'h00BC, 1, 1);
    chk("broken_ready", o_state, ST_READY);
    i_clear = 1; step(); i_clear = 0;
    chk("clear_err_in_ready", o_err_cnt, 0);
    chk("clear_keeps_ready", o_state, ST_READY);

    // comma watchdog
    i_rx_valid = 0;
    repeat (CTO - 1) step();
    chk("watchdog_hold", o_state, ST_READY);
    step();
    chk("watchdog_retrain", o_state, ST_TRAIN);
    send(1, 16'h00BC, 1, SYNC);
    chk("ready_after_watchdog", o_state, ST_READY);

    // priority cases
    i_start = 1; i_stop = 1; step(); i_start = 0; i_stop = 0;
    chk("start_stop_same", o_state, ST_READY);
    chk("start_stop_no_pulse", o_dp_start, 0);
    i_mode = 3'd6; i_start = 1; step(); i_start = 0;
    chk("run_mode6", o_dp_mode, 6);
    i_link_en = 0; step();
    chk("link_drop_off", o_state, ST_OFF);
    chk("link_drop_enable", o_enable, 0);
    i_link_en = 1; step();
    chk("link_back_pwrup", o_state, ST_PWRUP);

    // async reset mid-operation
    repeat (10) step();
    #2 arst_n = 1'b0;
    #1;
    chk("async_rst_state", o_state, ST_OFF);
    chk("async_rst_enable", o_enable, 0);
    #2 arst_n = 1'b1;

`ifdef TLK2711_PRBS_SELFTEST_EN
    i_rx_valid = 0; i_rklsb = 1;
    wait_state(ST_PRBS, 300, "prbs_entered");
    repeat (300) step();
    i_rklsb = 0; step(); i_rklsb = 1;
    chk("prbs_still_running", o_state, ST_PRBS);
    wait_state(ST_FAULT, 200, "prbs_fault");
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
